// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage load/store controller: one valid/ready data-memory request per ld/st,
// load alignment/extension and pipeline hold. Optional misaligned trap: LSU_MISALIGN_TRAP_EN.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        MEM_op,
  input  logic [2:0]        MEM_func3,
  input  logic [ADDR_W-1:0] MEM_cal_out,
  input  logic [31:0]       MEM_rs2_data,
  input  logic              pipe_stall,
  output logic              mem_wait,
  output logic [31:0]       MEM_ld_data,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic [ADDR_W-1:0] dm_req_addr,
  output logic [3:0]        dm_req_wstrb,
  output logic [31:0]       dm_req_wdata,
  input  logic              dm_resp_valid,
  input  logic [31:0]       dm_resp_rdata,
  output logic              misalign_exc
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                is_ld_q, is_ld_d;
  logic [2:0]          func3_q, func3_d;
  logic [1:0]          off_q, off_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [STRB_W-1:0]   req_wstrb_q, req_wstrb_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
`endif

  logic                is_ld_c, is_st_c, is_mem_c, mis_c;
  logic [1:0]          off_c;
  logic [STRB_W-1:0]   st_strb_c;
  logic [DATA_W-1:0]   st_wdata_c;
  logic [DATA_W-1:0]   rd_shift_c, ld_ext_c;

  assign is_ld_c  = (MEM_op == OP_LOAD);
  assign is_st_c  = (MEM_op == OP_STORE);
  assign is_mem_c = is_ld_c | is_st_c;
  assign off_c    = MEM_cal_out[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need an even address, words a 4-byte aligned one.
  assign mis_c = is_mem_c &&
                 (((MEM_func3[1:0] == 2'b01) && off_c[0]) ||
                  (MEM_func3[1] && (off_c != 2'b00)));
`else
  assign mis_c = 1'b0;
`endif

  // Store lane encoding; lanes pushed past byte 3 fall off the top.
  always_comb begin
    st_strb_c  = '0;
    st_wdata_c = '0;
    if (is_st_c) begin
      case (MEM_func3[1:0])
        2'b00: begin
          st_strb_c  = STRB_W'(4'b0001 << off_c);
          st_wdata_c = {4{MEM_rs2_data[7:0]}};
        end
        2'b01: begin
          st_strb_c  = STRB_W'(4'b0011 << off_c);
          st_wdata_c = {2{MEM_rs2_data[15:0]}};
        end
        default: begin
          st_strb_c  = STRB_W'(4'b1111 << off_c);
          st_wdata_c = DATA_W'(MEM_rs2_data << {off_c, 3'b000});
        end
      endcase
    end
  end

  // Load extract from the byte offset captured at issue.
  always_comb begin
    rd_shift_c = dm_resp_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  ld_ext_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
      3'b001:  ld_ext_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
      3'b100:  ld_ext_c = {24'b0, rd_shift_c[7:0]};
      3'b101:  ld_ext_c = {16'b0, rd_shift_c[15:0]};
      default: ld_ext_c = rd_shift_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    is_ld_d     = is_ld_q;
    func3_d     = func3_q;
    off_d       = off_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    ld_data_d   = ld_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (is_mem_c) begin
          is_ld_d = is_ld_c;
          func3_d = MEM_func3;
          off_d   = off_c;
          if (mis_c) begin
            state_d   = S_DONE;
            ld_data_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = {MEM_cal_out[ADDR_W-1:2], 2'b00};
            req_wstrb_d = st_strb_c;
            req_wdata_d = st_wdata_c;
          end
        end
      end
      S_REQ: begin
        if (dm_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dm_resp_valid) begin
          state_d = S_DONE;
          if (is_ld_q) begin
            ld_data_d = ld_ext_c;
          end
        end
      end
      S_DONE: begin
        // Holding here until the pipe moves keeps the same op from re-issuing.
        if (!pipe_stall) begin
          state_d = S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_ld_q     <= 1'b0;
      func3_q     <= '0;
      off_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
      ld_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_ld_q     <= is_ld_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      ld_data_q   <= ld_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Stall must reach the pipeline registers in the same cycle the op is seen.
  assign mem_wait = !rst && (((state_q == S_IDLE) && is_mem_c) ||
                             (state_q == S_REQ) || (state_q == S_WAIT));

  assign dm_req_valid = req_valid_q;
  assign dm_req_addr  = req_addr_q;
  assign dm_req_wstrb = req_wstrb_q;
  assign dm_req_wdata = req_wdata_q;
  assign MEM_ld_data  = ld_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_exc = misalign_q;
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store controller in the MEM stage of the 5-stage RV32 core. Issues one data-memory request per load/store over a valid/ready request channel and waits for the response. Aligns and sign-extends load data, and drives `mem_wait` so the MEM/WB pipeline register and upstream stages hold until the access completes. It is the producer of `mem_wait` and `MEM_ld_data` consumed by the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MEM_op`  in  7  opcode of the instruction in MEM; load = 7'b0000011, store = 7'b0100011.
- `MEM_func3`  in  3  width/sign selector: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `MEM_cal_out`  in  ADDR_W  effective byte address.
- `MEM_rs2_data`  in  32  store data, right-justified.
- `pipe_stall`  in  1  another stall source is holding MEM this cycle.
- `mem_wait`  out  1  stall request to the pipeline registers.
- `MEM_ld_data`  out  32  aligned, extended load result.
- `dm_req_valid`  out  1  request valid.
- `dm_req_ready`  in  1  memory accepts request.
- `dm_req_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `dm_req_wstrb`  out  4  byte write strobe; all 0 = read.
- `dm_req_wdata`  out  32  lane-shifted store data.
- `dm_resp_valid`  in  1  one-cycle response/ack pulse; no backpressure.
- `dm_resp_rdata`  in  32  read word, valid with `dm_resp_valid`.
- `misalign_exc`  out  1  misaligned-access flag.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `MEM_op` is a load or store, latch op/func3/addr/data, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `dm_req_valid` = 1; request fields stay stable until the handshake.
  - Handshake is `valid & ready`; on it, go to WAIT.
- WAIT:
  - On `dm_resp_valid`, go to DONE.
  - For loads, also register the aligned result into `MEM_ld_data`.
- DONE:
  - Return to IDLE when `pipe_stall` = 0; otherwise hold DONE.
  - Holding DONE stops the same instruction from being re-issued.
- `mem_wait` (combinational) = 1 when (IDLE and `MEM_op` is ld/st) or state is REQ or WAIT. It is 0 in DONE and while `rst` = 1.
- Write strobe and data by func3:
  - SB: `wstrb` = 1<<addr[1:0], data = byte replicated to all lanes.
  - SH: `wstrb` = 4'b0011<<addr[1:0], data = halfword replicated.
  - SW: `wstrb` = 4'b1111.
  - Loads: `wstrb` = 0.
- Load extract:
  - Shift `rdata` right by 8·addr[1:0], then take byte/half.
  - B/H sign-extend; BU/HU zero-extend; W passes the word.
- Stores leave `MEM_ld_data` unchanged.
- Boundary conditions:
  - `dm_resp_valid` in IDLE, REQ or DONE is ignored.
  - `dm_req_ready` outside REQ is ignored.
  - `rst` asserted in REQ or WAIT goes to IDLE and drops `dm_req_valid` the next cycle; a late response is ignored.
  - A new ld/st directly after DONE is issued normally from IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `dm_req_valid` 0, `dm_req_addr` 0, `dm_req_wstrb` 0, `dm_req_wdata` 0.
  - `MEM_ld_data` 0, `misalign_exc` 0, `mem_wait` 0.
- Request fields are registered.
- Best case, load seen at cycle t:
  - t+1 REQ (ready = 1).
  - t+2 WAIT (resp = 1).
  - t+3 DONE with data on `MEM_ld_data`.
  - `mem_wait` high for cycles t..t+2.
- Each extra cycle of ready-low or response delay adds one `mem_wait` cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, issues no request.
  - FSM goes IDLE→DONE directly.
  - `misalign_exc` = 1 during DONE; `MEM_ld_data` = 0.
  - `mem_wait` high only in the detect cycle.
- Undefined:
  - `misalign_exc` is tied 0.
  - Misaligned accesses are issued as-is; lanes shifted past byte 3 are dropped (no wrap).

## Test plan
- LW addr 0x104, ready = 1, rdata 0xDEADBEEF one cycle after accept -> `dm_req_addr` 0x104, `wstrb` 0; `mem_wait` high 3 cycles; `MEM_ld_data` 0xDEADBEEF in DONE.
- LB addr 0x203, rdata 0x80FF_FFFF -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x202, rdata 0xBEEF0000 -> 0x0000BEEF.
- SB addr 0x11, rs2 0x12345678 -> `wstrb` 4'b0010, `wdata` 0x78787878, addr 0x10. SH addr 0x12 -> `wstrb` 4'b1100, `wdata` 0x56785678.
- Ready low 4 cycles then high -> `dm_req_valid` held and fields stable; `mem_wait` high 7 cycles total.
- `rst` pulsed in WAIT, resp arrives the following cycle -> IDLE; `dm_req_valid` 0; `MEM_ld_data` 0; no DONE entered.
- With `LSU_MISALIGN_TRAP_EN`, LW addr 0x102 -> no `dm_req_valid`; `misalign_exc` 1 for one cycle. Without the macro -> request issued at 0x100 with `wstrb` 0.
